// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC, in-order imem requests, instruction FIFO, redirect squash
module fetch_unit #(
  parameter int              AW       = 32,
  parameter int              DW       = 32,
  parameter logic [AW-1:0]   RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          imem_req_valid,
  input  logic          imem_req_ready,
  output logic [AW-1:0] imem_req_addr,
  input  logic          imem_rsp_valid,
  input  logic [DW-1:0] imem_rsp_data,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [DW-1:0] inst,
  output logic [AW-1:0] inst_pc,
  output logic [6:0]    opcode,
  output logic [2:0]    func3,
  output logic [6:0]    func7,
  output logic [4:0]    rd,
  output logic [4:0]    rs1,
  output logic [4:0]    rs2
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // run holds requests off while reset is asserted and for the first cycle after
  logic          run;
  logic [AW-1:0] pc;
  logic [AW-1:0] enq_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] fifo_count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [DW-1:0] fifo_data [DEPTH];
  logic [AW-1:0] fifo_pc   [DEPTH];

  logic          accept;
  logic          dropping;
  logic          push;
  logic          pop;
  logic [CW:0]   in_use;
  logic [CW-1:0] outstanding_nxt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Every in-flight request owns a FIFO slot, so the FIFO can never overflow
  assign in_use          = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_req_valid  = run && (in_use < (CW+1)'(DEPTH));
  assign imem_req_addr   = pc;
  assign accept          = imem_req_valid && imem_req_ready;
  assign dropping        = (drop_cnt != '0);
  assign push            = imem_rsp_valid && !dropping && !redirect_valid;
  assign inst_valid      = (fifo_count != '0);
  assign pop             = inst_valid && inst_ready && !redirect_valid;
  assign outstanding_nxt = outstanding + CW'(accept) - CW'(imem_rsp_valid);

  // Head is read straight from registered storage; zeros when empty
  assign inst    = inst_valid ? fifo_data[rd_ptr] : '0;
  assign inst_pc = inst_valid ? fifo_pc[rd_ptr]   : enq_pc;
  assign opcode  = inst[6:0];
  assign func3   = inst[14:12];
  assign func7   = inst[31:25];
  assign rd      = inst[11:7];
  assign rs1     = inst[19:15];
  assign rs2     = inst[24:20];

  // Request enable comes up one cycle after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  // Fetch PC and the PC tagged onto the next kept response; redirect overrides both
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      enq_pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc     <= redirect_pc;
      enq_pc <= redirect_pc;
    end else begin
      if (accept) pc     <= pc + AW'(4);
      if (push)   enq_pc <= enq_pc + AW'(4);
    end
  end

  // In-flight/drop counters and FIFO occupancy; redirect flushes and arms the squash count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
      drop_cnt    <= '0;
      fifo_count  <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect_valid) begin
        drop_cnt   <= outstanding_nxt;
        fifo_count <= '0;
        rd_ptr     <= '0;
        wr_ptr     <= '0;
      end else begin
        if (imem_rsp_valid && dropping) drop_cnt <= drop_cnt - CW'(1);
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
        if (push) wr_ptr <= ptr_inc(wr_ptr);
        if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      end
    end
  end

  // FIFO storage needs no reset: occupancy gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= imem_rsp_data;
      fifo_pc[wr_ptr]   <= enq_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;
  localparam int          AW       = 32;
  localparam int          DW       = 32;
  localparam int          DEPTH    = 3;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic          clk;
  logic          rst_n;
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [AW-1:0] imem_req_addr;
  logic          imem_rsp_valid;
  logic [DW-1:0] imem_rsp_data;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          inst_valid;
  logic          inst_ready;
  logic [DW-1:0] inst;
  logic [AW-1:0] inst_pc;
  logic [6:0]    opcode;
  logic [2:0]    func3;
  logic [6:0]    func7;
  logic [4:0]    rd;
  logic [4:0]    rs1;
  logic [4:0]    rs2;

  fetch_unit #(.AW(AW), .DW(DW), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .opcode(opcode), .func3(func3), .func7(func7), .rd(rd), .rs1(rs1), .rs2(rs2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_data_q[$];

  int          n_vec;
  int          n_err;
  int          cyc;
  int          lat;
  int          n_acc;
  int          n_pop;
  bit          got_pop;
  logic [31:0] exp_req_pc;
  logic [31:0] last_acc_addr;
  logic [31:0] last_pop_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h200) return 32'h40B5_0533;
    return {a[15:0] ^ 16'hC0DE, a[15:0]};
  endfunction

  // One clock: score this cycle's accept/pop/response, then advance the memory model
  task automatic tick();
    mreq_t       h;
    logic [31:0] epc;
    logic [31:0] edata;
    bit          acc;
    bit          pop;
    acc = imem_req_valid && imem_req_ready;
    pop = inst_valid && inst_ready && !redirect_valid;
    if (acc) begin
      n_vec++;
      if (imem_req_addr !== exp_req_pc) begin
        n_err++;
        $display("FAIL req_addr: got %h want %h (cycle %0d)", imem_req_addr, exp_req_pc, cyc);
      end
      n_acc++;
      last_acc_addr = imem_req_addr;
    end
    if (!inst_valid) begin
      n_vec++;
      if (inst !== '0) begin
        n_err++;
        $display("FAIL empty_inst: got %h want 0 (cycle %0d)", inst, cyc);
      end
    end
    if (pop) begin
      n_pop++;
      got_pop     = 1'b1;
      last_pop_pc = inst_pc;
      n_vec++;
      if (exp_pc_q.size() == 0) begin
        n_err++;
        $display("FAIL pop_unexpected: got pc %h data %h want nothing (cycle %0d)", inst_pc, inst, cyc);
      end else begin
        epc   = exp_pc_q.pop_front();
        edata = exp_data_q.pop_front();
        if (inst_pc !== epc || inst !== edata) begin
          n_err++;
          $display("FAIL pop_data: got pc %h data %h want pc %h data %h (cycle %0d)",
                   inst_pc, inst, epc, edata, cyc);
        end
      end
    end
    if (imem_rsp_valid && mem_q.size() > 0) begin
      h = mem_q.pop_front();
      if (!h.stale && !redirect_valid) begin
        exp_pc_q.push_back(h.addr);
        exp_data_q.push_back(mem_word(h.addr));
      end
    end
    if (redirect_valid) begin
      foreach (mem_q[i]) mem_q[i].stale = 1'b1;
      exp_pc_q.delete();
      exp_data_q.delete();
    end
    if (acc) begin
      h.addr  = imem_req_addr;
      h.due   = cyc + lat;
      h.stale = redirect_valid;
      mem_q.push_back(h);
    end
    if (redirect_valid) exp_req_pc = redirect_pc;
    else if (acc)       exp_req_pc = exp_req_pc + 32'd4;
    @(posedge clk);
    #1;
    cyc++;
    redirect_valid = 1'b0;
    if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_q[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  endtask

  task automatic apply_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    mem_q.delete();
    exp_pc_q.delete();
    exp_data_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    exp_req_pc = RESET_PC;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_vec += 6;
    if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
    if (inst_valid !== 1'b0)     begin n_err++; $display("FAIL rst_inst_valid: got %b want 0", inst_valid); end
    if (inst !== '0)             begin n_err++; $display("FAIL rst_inst: got %h want 0", inst); end
    if (inst_pc !== RESET_PC)    begin n_err++; $display("FAIL rst_inst_pc: got %h want %h", inst_pc, RESET_PC); end
    if (imem_req_addr !== RESET_PC) begin n_err++; $display("FAIL rst_req_addr: got %h want %h", imem_req_addr, RESET_PC); end
    if ({opcode, func3, func7, rd, rs1, rs2} !== '0) begin n_err++; $display("FAIL rst_fields: got %h want 0", {opcode, func3, func7, rd, rs1, rs2}); end
    apply_reset();
  endtask

  task automatic test_stream();
    apply_reset();
    lat = 1;
    repeat (8) tick();
    n_pop = 0;
    repeat (12) tick();
    n_vec++;
    if (n_pop != 12) begin n_err++; $display("FAIL stream_rate: got %0d pops want 12", n_pop); end
  endtask

  task automatic test_stall();
    int k;
    apply_reset();
    lat        = 1;
    inst_ready = 1'b0;
    n_acc      = 0;
    repeat (10) tick();
    n_vec += 3;
    if (n_acc != DEPTH)          begin n_err++; $display("FAIL stall_accepts: got %0d want %0d", n_acc, DEPTH); end
    if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL stall_req_valid: got %b want 0", imem_req_valid); end
    if (inst_pc !== RESET_PC)    begin n_err++; $display("FAIL stall_head_pc: got %h want %h", inst_pc, RESET_PC); end
    inst_ready = 1'b1;
    n_acc      = 0;
    k          = 0;
    while (n_acc == 0 && k < 10) begin tick(); k++; end
    n_vec++;
    if (n_acc == 0)                       begin n_err++; $display("FAIL stall_resume: got no request want one within 10 cycles"); end
    else if (last_acc_addr !== 32'(4*DEPTH)) begin n_err++; $display("FAIL stall_resume_addr: got %h want %h", last_acc_addr, 32'(4*DEPTH)); end
    repeat (10) tick();
  endtask

  task automatic test_redirect();
    int k;
    apply_reset();
    lat = 2;
    k   = 0;
    while (mem_q.size() != 2 && k < 20) begin tick(); k++; end
    n_vec++;
    if (mem_q.size() != 2) begin n_err++; $display("FAIL redir_inflight: got %0d in flight want 2", mem_q.size()); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    got_pop = 1'b0;
    k       = 0;
    while (!got_pop && k < 20) begin tick(); k++; end
    n_vec++;
    if (!got_pop)                     begin n_err++; $display("FAIL redir_first: got no instruction want pc 100"); end
    else if (last_pop_pc !== 32'h100) begin n_err++; $display("FAIL redir_first_pc: got %h want 00000100", last_pop_pc); end
    repeat (8) tick();
  endtask

  task automatic test_redirect_collide();
    int k;
    apply_reset();
    lat = 1;
    repeat (5) tick();
    k = 0;
    while (!(imem_req_valid && imem_rsp_valid) && k < 20) begin tick(); k++; end
    n_vec++;
    if (!(imem_req_valid && imem_rsp_valid)) begin n_err++; $display("FAIL collide_setup: got no req+rsp cycle want one"); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    n_vec += 2;
    if (imem_req_valid !== 1'b1)     begin n_err++; $display("FAIL collide_req_valid: got %b want 1", imem_req_valid); end
    if (imem_req_addr !== 32'h100)   begin n_err++; $display("FAIL collide_req_addr: got %h want 00000100", imem_req_addr); end
    got_pop = 1'b0;
    k       = 0;
    while (!got_pop && k < 20) begin tick(); k++; end
    n_vec++;
    if (!got_pop || last_pop_pc !== 32'h100) begin n_err++; $display("FAIL collide_first_pc: got %h (popped %b) want 00000100", last_pop_pc, got_pop); end
    repeat (6) tick();
  endtask

  task automatic test_full_pushpop();
    apply_reset();
    lat   = 1;
    n_pop = 0;
    repeat (40) begin
      inst_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    lat = 2;
    repeat (40) begin
      inst_ready     = ($urandom_range(0, 1) != 0);
      imem_req_ready = (mem_q.size() == 0) ? ($urandom_range(0, 3) != 0) : imem_req_ready;
      tick();
    end
    imem_req_ready = 1'b0;
    inst_ready     = 1'b1;
    repeat (12) tick();
    n_vec += 3;
    if (exp_pc_q.size() != 0) begin n_err++; $display("FAIL pushpop_leftover: got %0d undrained want 0", exp_pc_q.size()); end
    if (inst_valid !== 1'b0)  begin n_err++; $display("FAIL pushpop_empty: got inst_valid %b want 0", inst_valid); end
    if (n_pop < 20)           begin n_err++; $display("FAIL pushpop_count: got %0d pops want >=20", n_pop); end
    imem_req_ready = 1'b1;
  endtask

  task automatic test_decode_reset();
    int k;
    apply_reset();
    lat            = 1;
    inst_ready     = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    k = 0;
    while (!inst_valid && k < 10) begin tick(); k++; end
    n_vec += 8;
    if (inst_pc !== 32'h200)       begin n_err++; $display("FAIL dec_pc: got %h want 00000200", inst_pc); end
    if (inst !== 32'h40B5_0533)    begin n_err++; $display("FAIL dec_inst: got %h want 40b50533", inst); end
    if (opcode !== 7'h33)          begin n_err++; $display("FAIL dec_opcode: got %h want 33", opcode); end
    if (func3 !== 3'd0)            begin n_err++; $display("FAIL dec_func3: got %h want 0", func3); end
    if (func7 !== 7'h20)           begin n_err++; $display("FAIL dec_func7: got %h want 20", func7); end
    if (rd !== 5'd10)              begin n_err++; $display("FAIL dec_rd: got %0d want 10", rd); end
    if (rs1 !== 5'd10)             begin n_err++; $display("FAIL dec_rs1: got %0d want 10", rs1); end
    if (rs2 !== 5'd11)             begin n_err++; $display("FAIL dec_rs2: got %0d want 11", rs2); end
    inst_ready = 1'b1;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_vec += 5;
    if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL async_req_valid: got %b want 0", imem_req_valid); end
    if (inst_valid !== 1'b0)     begin n_err++; $display("FAIL async_inst_valid: got %b want 0", inst_valid); end
    if (inst !== '0)             begin n_err++; $display("FAIL async_inst: got %h want 0", inst); end
    if (inst_pc !== RESET_PC)    begin n_err++; $display("FAIL async_inst_pc: got %h want %h", inst_pc, RESET_PC); end
    if (imem_req_addr !== RESET_PC) begin n_err++; $display("FAIL async_req_addr: got %h want %h", imem_req_addr, RESET_PC); end
    apply_reset();
    repeat (4) tick();
  endtask

  initial begin
    n_vec          = 0;
    n_err          = 0;
    cyc            = 0;
    lat            = 1;
    n_acc          = 0;
    n_pop          = 0;
    got_pop        = 1'b0;
    exp_req_pc     = RESET_PC;
    last_acc_addr  = '0;
    last_pop_pc    = '0;
    rst_n          = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b1;
    #1;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_collide();
    test_full_pushpop();
    test_decode_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
